// File: rtl/mor1kx_icache_refill_wbm_pkg.sv
// Shared definitions for the instruction-cache refill Wishbone master.
// Holds the Wishbone B3 cycle-type and burst-type codes, the refill FSM
// state encoding, and a helper that maps the cache line size onto the
// wrapping burst type the interconnect expects.
package mor1kx_icache_refill_wbm_pkg;

    // Wishbone cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Wishbone burst type extensions
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;

    // Refill master states: waiting, fetching the line, waiting for the
    // cache to release its request before another refill may start.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // A 16-byte line is a 4-beat wrap, a 32-byte line an 8-beat wrap.
    function automatic logic [1:0] bteForBlock(input int blockWidth);
        return (blockWidth == 4) ? BTE_WRAP4 : BTE_WRAP8;
    endfunction

endpackage

// File: rtl/mor1kx_icache_refill_wbm_if.sv
// Wishbone B3 instruction-bus interface between the refill master and the
// bus arbiter/interconnect.
//   master modport: drives adr/stb/cyc/sel/we/cti/bte, receives dat/ack/err/rty
//   slave  modport: the mirror image, for a bus model or interconnect port
interface mor1kx_icache_refill_wbm_if;
    import mor1kx_icache_refill_wbm_pkg::*;

    logic [31:0] wbm_adr_o;
    logic        wbm_stb_o;
    logic        wbm_cyc_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_rty_i;

    modport master (
        output wbm_adr_o, wbm_stb_o, wbm_cyc_o, wbm_sel_o, wbm_we_o,
               wbm_cti_o, wbm_bte_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );

    modport slave (
        input  wbm_adr_o, wbm_stb_o, wbm_cyc_o, wbm_sel_o, wbm_we_o,
               wbm_cti_o, wbm_bte_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );

endinterface

// File: rtl/mor1kx_burst_adr_wrap.sv
// Combinational next-beat address for a wrapping burst: the word index
// inside the cache line increments modulo the number of beats while the
// line address above it and the byte offset below it pass through.
//   adr_i : current bus address
//   adr_o : address of the following beat within the same line
module mor1kx_burst_adr_wrap #(
    parameter int ADR_WIDTH   = 32,
    parameter int BLOCK_WIDTH = 5
) (
    input  logic [ADR_WIDTH-1:0] adr_i,
    output logic [ADR_WIDTH-1:0] adr_o
);

    localparam int IDX_W = BLOCK_WIDTH - 2;

    logic [IDX_W-1:0] idxNext;

    // Natural overflow of the index field gives the wrap back to word 0.
    always_comb begin
        idxNext = adr_i[BLOCK_WIDTH-1:2] + {{(IDX_W-1){1'b0}}, 1'b1};
        adr_o   = {adr_i[ADR_WIDTH-1:BLOCK_WIDTH], idxNext, adr_i[1:0]};
    end

endmodule

// File: rtl/mor1kx_icache_refill_wbm.sv
// Wishbone B3 burst master feeding the instruction-cache refill port.
// A refill request fetches one cache line critical word first using a
// wrapping incrementing burst, streams each returned word to the cache
// write port, and reports bus errors (err or rty) as a one-cycle pulse.
//   clk, rst              : clock, synchronous active-high reset
//   refill_req_i/_adr_i   : refill request and miss address from the cache
//   wradr_o/wrdat_o/we_o  : cache write port, one strobe per returned beat
//   imem_err_o            : one-cycle bus error pulse to the cache
//   busy_o                : high while a refill is outstanding or draining
//   wbm                   : Wishbone master port
module mor1kx_icache_refill_wbm
    import mor1kx_icache_refill_wbm_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            refill_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
    output logic                            we_o,
    output logic                            imem_err_o,
    output logic                            busy_o,
    mor1kx_icache_refill_wbm_if.master      wbm
);

    localparam int W     = OPTION_OPERAND_WIDTH;
    localparam int CNT_W = OPTION_ICACHE_BLOCK_WIDTH - 2;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LOAD   = '1;
    localparam logic [W-1:0]     WORD_ALIGN = {{(W-2){1'b1}}, 2'b00};
    localparam logic [1:0]       BTE_LINE   = bteForBlock(OPTION_ICACHE_BLOCK_WIDTH);

    state_e           state_q, state_d;
    logic [W-1:0]     adr_q, adr_d, adrNext;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cyc_q, cyc_d, stb_q, stb_d;
    logic [2:0]       cti_q, cti_d;
    logic [1:0]       bte_q, bte_d;
    logic [W-1:0]     wradr_q, wradr_d, wrdat_q, wrdat_d;
    logic             we_q, we_d, err_q, err_d, busy_q, busy_d;

    mor1kx_burst_adr_wrap #(
        .ADR_WIDTH   (W),
        .BLOCK_WIDTH (OPTION_ICACHE_BLOCK_WIDTH)
    ) u_adr_wrap (
        .adr_i (adr_q),
        .adr_o (adrNext)
    );

    // Next-state logic. The counter holds the beats still to be acked
    // minus one, so reaching zero means the final beat is on the bus and
    // the cycle type switches to end-of-burst for it. An error or retry
    // wins over a simultaneous ack and abandons the rest of the line.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        cti_d   = cti_q;
        bte_d   = bte_q;
        wradr_d = wradr_q;
        wrdat_d = wrdat_q;
        we_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (refill_req_i) begin
                    adr_d   = refill_adr_i & WORD_ALIGN;
                    cnt_d   = CNT_LOAD;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cti_d   = CTI_INCR;
                    bte_d   = BTE_LINE;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (wbm.wbm_err_i || wbm.wbm_rty_i) begin
                    err_d   = 1'b1;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    cti_d   = CTI_CLASSIC;
                    state_d = ST_DRAIN;
                end else if (wbm.wbm_ack_i) begin
                    wrdat_d = wbm.wbm_dat_i;
                    wradr_d = adr_q;
                    we_d    = 1'b1;
                    adr_d   = adrNext;
                    if (cnt_q == '0) begin
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        cti_d   = CTI_CLASSIC;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            cti_d = CTI_EOB;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!refill_req_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any burst silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            cti_q   <= CTI_CLASSIC;
            bte_q   <= BTE_LINEAR;
            wradr_q <= '0;
            wrdat_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            cti_q   <= cti_d;
            bte_q   <= bte_d;
            wradr_q <= wradr_d;
            wrdat_q <= wrdat_d;
            we_q    <= we_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_stb_o = stb_q;
    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_sel_o = 4'hf;
    assign wbm.wbm_we_o  = 1'b0;
    assign wbm.wbm_cti_o = cti_q;
    assign wbm.wbm_bte_o = bte_q;
    assign wradr_o       = wradr_q;
    assign wrdat_o       = wrdat_q;
    assign we_o          = we_q;
    assign imem_err_o    = err_q;
    assign busy_o        = busy_q;

endmodule

// File: doc/mor1kx_icache_refill_wbm.md
Name: mor1kx_icache_refill_wbm

Overview:
- Wishbone B3 burst master that feeds the instruction cache refill port.
- On a refill request it fetches one cache line, critical word first, using wrapping incrementing bursts.
- Streams each returned word to the cache write port (wradr/wrdat/we) and reports bus errors back to the cache FSM.
- Sits between the icache and the instruction bus arbiter/interconnect.

Parameters:
- OPTION_OPERAND_WIDTH, 32, data/address width; only 32 supported.
- OPTION_ICACHE_BLOCK_WIDTH, 5, log2 line bytes; only 4 (4 beats, BTE=01) or 5 (8 beats, BTE=10) legal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- refill_req_i  in  1  cache requests refill or is refilling
- refill_adr_i  in  32  miss address (cache match address); bits [1:0] ignored
- wradr_o  out  32  refill write address to cache
- wrdat_o  out  32  refill write data to cache
- we_o  out  1  refill write strobe, one cycle per beat
- imem_err_o  out  1  one-cycle bus error pulse to cache
- busy_o  out  1  high whenever state != IDLE
- wbm_adr_o  out  32  bus address
- wbm_stb_o  out  1  strobe
- wbm_cyc_o  out  1  cycle
- wbm_sel_o  out  4  byte selects, constant 4'hf
- wbm_we_o  out  1  constant 0
- wbm_cti_o  out  3  cycle type
- wbm_bte_o  out  2  burst type
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  beat acknowledge
- wbm_err_i  in  1  bus error
- wbm_rty_i  in  1  retry; treated exactly as err

Behaviour:
- Reset values: cyc/stb/we_o/imem_err_o/busy_o = 0; adr/wradr/wrdat = 0; cti = 3'b000; bte = 2'b00; state IDLE. Reset mid-burst drops cyc/stb at that edge with no we_o and no err pulse.
- All outputs are registered.
- States: IDLE, BURST, DRAIN.
- IDLE:
  - On refill_req_i=1: latch {refill_adr_i[31:2],2'b00} into wbm_adr_o; load beat counter = beats-1.
  - cyc=stb=1 from the next cycle; cti=010; bte per parameter.
  - Go to BURST.
- BURST:
  - stb held high continuously (zero-wait bus gives 1 beat/clk).
  - On ack: wrdat_o<=wbm_dat_i, wradr_o<=wbm_adr_o, we_o<=1 for one cycle (latency ack->we = 1 clk).
  - On ack: wbm_adr_o low bits [BLOCK_WIDTH-1:2] increment mod beats, upper bits fixed (wrap within line).
  - On ack: counter decrements.
  - When the counter reaches 0 after an ack (last beat now outstanding), cti<=111.
  - Ack of the final beat: cyc/stb<=0, cti<=000, go to DRAIN.
- Error or retry (err|rty) in BURST:
  - That beat produces no we_o; imem_err_o=1 for one cycle.
  - cyc/stb<=0; go to DRAIN.
  - ack together with err is treated as err.
- DRAIN: remain until refill_req_i=0, then IDLE. This prevents restarting while the cache is still in REFILL or is consuming the final write.
- Beat ordering: the first we_o carries the critical word (refill_adr_i word), so the cache refill hit fires early.
- refill_adr_i is sampled only in IDLE; later changes are ignored.
- An ack while cyc=0 is ignored.

Decomposition:
- Shared package holds:
  - WB CTI constants: CLASSIC=000, INCR=010, EOB=111.
  - BTE constants: LINEAR=00, WRAP4=01, WRAP8=10.
  - State encoding for IDLE/BURST/DRAIN.
- One sub-module, mor1kx_burst_adr_wrap: combinational wrap increment of the word index within the line, given BLOCK_WIDTH.
- FSM, counter and registers stay in the top module.

Test Plan:
- BLOCK_WIDTH=5, refill_adr_i=0x1008, ack every cycle:
  - adr sequence 1008,100C,1010,1014,1018,101C,1000,1004.
  - cti 010 x7 then 111; bte=10.
  - 8 we_o pulses, each 1 clk after its ack, wradr/wrdat matching.
  - cyc drops after the 8th ack.
- Same burst with 2 wait states per beat: stb held throughout; exactly 8 we_o pulses; address advances only on ack.
- BLOCK_WIDTH=4, refill_adr_i=0x2004: adr 2004,2008,200C,2000; bte=01; cti=111 on the 4th beat only.
- err asserted on the 3rd beat: 2 we_o pulses only; imem_err_o single pulse; cyc/stb low next cycle; DRAIN until refill_req_i falls, then IDLE.
- refill_req_i held high 5 cycles after the last beat: no new cyc in DRAIN. A new req after it falls starts a fresh burst.
- rst asserted during beat 4: cyc/stb/we_o low at the next edge; no imem_err_o; a subsequent request restarts cleanly from IDLE.
